kbd_matrix: RTL
===============

KBD_MATRIX -- requirements
Module: kbd_matrix

Interface
REQ-001 SHALL have parameter ROWS, default 10, number of matrix rows (1..16).
REQ-002 SHALL have parameter HOLD_SCANS, default 2, CPU row reads a newly pressed key is guaranteed visible for (1..15).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2**22, clk_bus_i cycles without host matrix write before auto-release (>=2).
REQ-004 SHALL have port clk_bus_i  in  1  bus clock; the only clock; all state updates on its falling edge.
REQ-005 SHALL have port reset_i  in  1  synchronous, active-high reset.
REQ-006 SHALL have port spi_addr_i  in  17  host write address.
REQ-007 SHALL have port spi_data_i  in  8  host row data, bit=0 means key pressed.
REQ-008 SHALL have port spi_wr_en_i  in  1  host write strobe, one cycle.
REQ-009 SHALL have port bus_addr_i  in  2  PIA register select.
REQ-010 SHALL have port bus_data_i  in  8  CPU write data.
REQ-011 SHALL have ports pia1_en_i, cpu_rd_en_i, cpu_wr_en_i  in  1 each  PIA1 select, CPU read strobe, CPU write strobe.
REQ-012 SHALL have port mode_i  in  1  0 = intercept only when a key is pressed, 1 = always intercept port B reads.
REQ-013 SHALL have port kbd_data_o  out  8  effective column data of the selected row.
REQ-014 SHALL have port kbd_en_o  out  1  drive kbd_data_o onto the data bus instead of PIA1.
REQ-015 SHALL have port stale_o  out  1  host timeout has expired and the matrix is forced released.

Function
REQ-016 Host matrix write SHALL be spi_wr_en_i with spi_addr_i[16:4]==13'hE80 and spi_addr_i[3:0]<ROWS; other indices SHALL be ignored.
REQ-017 CPU write with pia1_en_i, cpu_wr_en_i, bus_addr_i==0 (PORTA) SHALL latch bus_data_i[3:0] as the selected row.
REQ-018 Row-read event SHALL be pia1_en_i, cpu_rd_en_i, bus_addr_i==2 (PORTB).
REQ-019 Each row SHALL hold stored[r] (last host data), eff[r] (effective data), hold_cnt[r] (4-bit).
REQ-020 A host write whose data has any bit 0 where eff[r] has 1 (new press) SHALL set eff[r] to eff[r] AND data and hold_cnt[r] to HOLD_SCANS.
REQ-021 While hold_cnt[r]!=0, further host writes SHALL add presses to eff[r] and SHALL defer releases; releases update stored[r] only.
REQ-022 Each row-read event with selected row r and hold_cnt[r]!=0 SHALL decrement hold_cnt[r] by 1 (saturate at 0).
REQ-023 When hold_cnt[r]==0, eff[r] SHALL equal stored[r] on the following edge.
REQ-024 Host write and row-read decrement to the same row in one cycle: write SHALL win (counter reloaded if a new press, else decrement applies).
REQ-025 Host write and PORTA write in one cycle SHALL both take effect.
REQ-026 kbd_data_o SHALL be registered: eff[selected row], or 8'hff if selected row >=ROWS; one-cycle latency from selection or eff change.
REQ-027 kbd_en_o SHALL be combinational: row-read event AND (mode_i OR kbd_data_o!=8'hff).
REQ-028 Idle counter SHALL reset to 0 on every host matrix write and increment otherwise, saturating at TIMEOUT_CYCLES.
REQ-029 On reaching TIMEOUT_CYCLES, all stored[r] and eff[r] SHALL become 8'hff, all hold_cnt[r] 0, stale_o 1.
REQ-030 A host write in the expiry cycle SHALL win: no expiry, counter restarts; stale_o SHALL clear on the next host matrix write.

Reset
REQ-031 reset_i SHALL set all stored[r], eff[r], kbd_data_o to 8'hff, hold_cnt[r] and selected row to 0, idle counter to 0, stale_o to 0.
REQ-032 reset_i SHALL override all same-cycle host and CPU activity, including mid-hold rows.

Structure
REQ-033 Package kbd_pkg SHALL hold PORTA/CRA/PORTB/CRB offsets, KBD_SPI_BASE (13'hE80) and COLS (8).
REQ-034 Per-row stored/eff/hold_cnt logic SHALL be sub-module kbd_row_hold, instantiated ROWS times via generate.

Verification
REQ-035 Reset, PORTA=3, PORTB read -> kbd_data_o 8'hff, kbd_en_o 0 (mode_i=0); mode_i=1 -> kbd_en_o 1.
REQ-036 Host write E803=8'hfe, PORTA=3, PORTB read -> kbd_data_o 8'hfe one cycle after selection, kbd_en_o 1.
REQ-037 Host E803=fe then E803=ff before any read -> reads 1 and 2 of row 3 return fe, read 3 returns ff.
REQ-038 Host write E80C with ROWS=10 -> ignored; PORTA=12 -> kbd_data_o 8'hff.
REQ-039 Host E800=7f then no writes for TIMEOUT_CYCLES -> stale_o 1, row 0 reads ff; next host write clears stale_o.
REQ-040 Host write E805=ef and PORTA=5 same cycle, then PORTB read -> ef; reset_i mid-hold -> ff, hold_cnt 0.

Source files
------------

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared constants for the keyboard matrix intercept.
//   PORTA/CRA/PORTB/CRB : PIA1 register offsets on bus_addr_i
//   KBD_SPI_BASE        : upper 13 bits of the host matrix write window
//   COLS                : columns per matrix row (bits per row byte)
package kbd_pkg;

    localparam logic [1:0]  PORTA        = 2'd0;
    localparam logic [1:0]  CRA          = 2'd1;
    localparam logic [1:0]  PORTB        = 2'd2;
    localparam logic [1:0]  CRB          = 2'd3;

    localparam logic [12:0] KBD_SPI_BASE = 13'hE80;
    localparam int          COLS         = 8;

endpackage

// File: rtl/kbd_row_hold.sv
// kbd_row_hold: one keyboard matrix row with press-hold behaviour.
//   clk       : bus clock, state updates on the falling edge
//   reset     : synchronous, active-high
//   host_wr   : host wrote this row this cycle (single-cycle strobe)
//   host_data : host row byte, bit=0 means key pressed
//   scan      : CPU read PORTB while this row was selected
//   expire    : host idle timeout, force the row released
//   eff       : effective row data presented to the CPU
// A newly pressed key is kept visible for HOLD_SCANS CPU scans even if the
// host reports its release before the CPU has looked at the row.
module kbd_row_hold
    import kbd_pkg::*;
#(
    parameter int HOLD_SCANS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            host_wr,
    input  logic [COLS-1:0] host_data,
    input  logic            scan,
    input  logic            expire,
    output logic [COLS-1:0] eff
);

    logic [COLS-1:0] stored;
    logic [3:0]      hold_cnt;
    logic            new_press;
    logic [COLS-1:0] stored_nxt;

    // A press is "new" only if it pulls down a bit the CPU currently sees high.
    assign new_press  = host_wr && (|(~host_data & eff));
    assign stored_nxt = host_wr ? host_data : stored;

    always_ff @(negedge clk) begin
        if (reset || expire) begin
            stored   <= '1;
            eff      <= '1;
            hold_cnt <= '0;
        end else begin
            stored <= stored_nxt;
            if (new_press) begin
                // Presses accumulate; releases in the same byte are deferred.
                eff      <= eff & host_data;
                hold_cnt <= 4'(HOLD_SCANS);
            end else if (hold_cnt != 4'd0) begin
                // Holding: releases only reach stored, eff stays put.
                if (scan) begin
                    hold_cnt <= hold_cnt - 4'd1;
                end
            end else begin
                eff <= stored_nxt;
            end
        end
    end

endmodule

// File: rtl/kbd_matrix.sv
// kbd_matrix: host-fed keyboard matrix that intercepts PIA1 port B reads.
//   clk_bus_i    : bus clock, all state updates on its falling edge
//   reset_i      : synchronous, active-high
//   spi_addr_i   : host write address (window KBD_SPI_BASE, low nibble = row)
//   spi_data_i   : host row data, bit=0 means key pressed
//   spi_wr_en_i  : host write strobe
//   bus_addr_i   : PIA register select
//   bus_data_i   : CPU write data (low nibble selects the row on PORTA)
//   pia1_en_i, cpu_rd_en_i, cpu_wr_en_i : PIA1 select and CPU strobes
//   mode_i       : 0 = intercept only while a key shows, 1 = always intercept
//   kbd_data_o   : registered column data of the selected row
//   kbd_en_o     : drive kbd_data_o onto the data bus instead of PIA1
//   stale_o      : host went silent too long, matrix forced released
// Strobe semantics: every *_en_i strobe is a single-cycle qualifier sampled on
// the falling edge; there is no back-pressure, each strobe is consumed at once.
module kbd_matrix
    import kbd_pkg::*;
#(
    parameter int ROWS           = 10,
    parameter int HOLD_SCANS     = 2,
    parameter int TIMEOUT_CYCLES = 2**22
) (
    input  logic        clk_bus_i,
    input  logic        reset_i,
    input  logic [16:0] spi_addr_i,
    input  logic [7:0]  spi_data_i,
    input  logic        spi_wr_en_i,
    input  logic [1:0]  bus_addr_i,
    input  logic [7:0]  bus_data_i,
    input  logic        pia1_en_i,
    input  logic        cpu_rd_en_i,
    input  logic        cpu_wr_en_i,
    input  logic        mode_i,
    output logic [7:0]  kbd_data_o,
    output logic        kbd_en_o,
    output logic        stale_o
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic              host_hit;
    logic              porta_wr;
    logic              row_rd;
    logic              expire;
    logic [3:0]        sel_row;
    logic [IDLE_W-1:0] idle_cnt;
    logic [COLS-1:0]   eff [ROWS];
    logic [COLS-1:0]   sel_data;
    logic              unused_bits;

    assign host_hit = spi_wr_en_i && (spi_addr_i[16:4] == KBD_SPI_BASE)
                      && ({1'b0, spi_addr_i[3:0]} < 5'(ROWS));
    assign porta_wr = pia1_en_i && cpu_wr_en_i && (bus_addr_i == PORTA);
    assign row_rd   = pia1_en_i && cpu_rd_en_i && (bus_addr_i == PORTB);

    // Expiry fires on the edge the counter would reach TIMEOUT_CYCLES; a host
    // write on that same edge suppresses it.
    assign expire   = !host_hit && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    assign unused_bits = ^bus_data_i[7:4];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        kbd_row_hold #(
            .HOLD_SCANS (HOLD_SCANS)
        ) u_row (
            .clk       (clk_bus_i),
            .reset     (reset_i),
            .host_wr   (host_hit && (spi_addr_i[3:0] == 4'(r))),
            .host_data (spi_data_i),
            .scan      (row_rd && (sel_row == 4'(r))),
            .expire    (expire),
            .eff       (eff[r])
        );
    end

    // Rows beyond ROWS read as all keys released.
    always_comb begin
        sel_data = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (sel_row == 4'(r)) begin
                sel_data = eff[r];
            end
        end
    end

    always_ff @(negedge clk_bus_i) begin
        if (reset_i) begin
            idle_cnt   <= '0;
            stale_o    <= 1'b0;
            sel_row    <= 4'd0;
            kbd_data_o <= 8'hff;
        end else begin
            if (host_hit) begin
                idle_cnt <= '0;
            end else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (host_hit) begin
                stale_o <= 1'b0;
            end else if (expire) begin
                stale_o <= 1'b1;
            end

            if (porta_wr) begin
                sel_row <= bus_data_i[3:0];
            end

            kbd_data_o <= sel_data;
        end
    end

    assign kbd_en_o = row_rd && (mode_i || (kbd_data_o != 8'hff));

endmodule
